ic_host_master: RTL and testbench
=================================

Name: ic_host_master

Overview:
- Processor-side counterpart of the interrupt controller. It is the APB-style initiator and interrupt-servicing end of the same interface.
- After start, it programs one priority register per interrupt line. It then services interrupts: waits for intr_valid_i, holds for a service delay, pulses intr_serviced_o and clears the serviced source.
- Used as synthesizable host model in system benches and as a boot-time configuration engine.

Parameters:
- NUM_INTR, 16, number of interrupt lines and priority registers.
- PRIO_W, 4, priority field width (log2 NUM_INTR).
- SERVICE_CYCLES, 3, cycles between service start and intr_serviced_o pulse; minimum 1.
- TIMEOUT_CYCLES, 15, max cycles to wait for pready_i per access.

Ports:
- pclk_i  in  1  clock, all logic on rising edge.
- prst_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  pulse; begins configuration from S_IDLE, ignored elsewhere.
- prio_cfg_i  in  NUM_INTR*PRIO_W  priority for line k at bits [k*PRIO_W +: PRIO_W]; sampled once on start_i.
- paddr_o  out  8  register address (= line index).
- pwdata_o  out  8  write data, priority zero-extended.
- pwrite_o  out  1  1 = write.
- penable_o  out  1  transfer active.
- prdata_i  in  8  read data, used only with readback.
- pready_i  in  1  transfer complete.
- perror_i  in  1  transfer error, valid with pready_i.
- intr_valid_i  in  1  controller presents an interrupt.
- intr_to_service_i  in  PRIO_W  index of the interrupt to service.
- intr_serviced_o  out  1  one-cycle service-complete pulse.
- intr_clear_o  out  NUM_INTR  one-hot, one-cycle clear to the serviced source.
- cfg_done_o  out  1  level; all registers programmed.
- cfg_error_o  out  1  sticky; any perror_i, timeout or readback mismatch.
- service_count_o  out  16  count of serviced interrupts, wraps at 0xFFFF→0.

Behaviour:
- Reset values: all outputs 0; state S_IDLE; index 0; counters 0.
- Reset asserted mid-transfer aborts the transfer immediately.
- A new start_i is required after reset.
- FSM, one-hot states:
  - S_IDLE → S_CFG_ACCESS on start_i. prio_cfg_i is latched into an internal array.
  - S_CFG_ACCESS drives paddr_o=idx, pwdata_o=prio[idx], pwrite_o=1, penable_o=1. It stays until pready_i=1 or TIMEOUT_CYCLES elapse.
  - A timeout or a perror_i with pready_i sets cfg_error_o. The failed access is not retried; go to S_CFG_GAP.
  - S_CFG_GAP holds one cycle with penable_o=0, pwrite_o=0, paddr_o=0, pwdata_o=0, then increments idx.
  - From S_CFG_GAP, idx==NUM_INTR-1 → S_WAIT_INTR with cfg_done_o=1; otherwise → S_CFG_ACCESS.
  - S_WAIT_INTR: on intr_valid_i=1, latch intr_to_service_i into svc_id, load svc counter, go to S_SERVICE.
  - S_SERVICE: counts SERVICE_CYCLES cycles, then → S_ACK.
  - S_ACK: one cycle with intr_serviced_o=1, intr_clear_o[svc_id]=1, service_count_o+1, then → S_DRAIN.
  - S_DRAIN: waits for intr_valid_i=0 before returning to S_WAIT_INTR. This prevents double service of a stale valid.
- Back-to-back transfers are separated by at least one idle cycle.
- Latency per config write = cycles to pready_i + 1.
- Total service latency from intr_valid_i to intr_serviced_o = SERVICE_CYCLES + 1 cycles.
- intr_to_service_i changing during S_SERVICE is ignored; svc_id is used.
- intr_valid_i during configuration is ignored until cfg_done_o.
- start_i outside S_IDLE is ignored.

Optional Feature:
- Macro IC_HOST_READBACK_EN.
- When defined: after each successful write, add S_RD_ACCESS, same address, pwrite_o=0, penable_o=1, same timeout rule.
  - On pready_i, compare prdata_i[PRIO_W-1:0] to the written value; a mismatch sets cfg_error_o.
  - A gap cycle follows before the next address.
- When undefined: no read transfers; prdata_i is unused.

Decomposition:
- Package ic_pkg holds NUM_INTR, PRIO_W, the APB address map constant (priority register base 0), and the one-hot state encodings.
- One sub-module, ic_host_timer: loadable down-counter with zero flag. It is shared for the access timeout and the service delay.

Test Plan:
- Priorities 0..15, pready_i responds after 2 cycles → 16 writes at addresses 0..15 with data equal to index; cfg_done_o rises after the 16th gap; cfg_error_o=0.
- pready_i held 0 on address 5 → access aborts after 15 cycles; cfg_error_o=1; address 6 is written next; cfg_done_o still reaches 1.
- After config, intr_valid_i=1 with id=9 → intr_serviced_o pulses 4 cycles later; intr_clear_o=0x0200; service_count_o=1.
- intr_valid_i held high for 3 cycles after the ack → no second service; count stays 1 until valid drops and reasserts.
- Reset asserted during S_SERVICE → all outputs 0 asynchronously; start_i is needed to reconfigure.
- With IC_HOST_READBACK_EN, a responder returns wrong data for address 3 → 32 transfers are issued; cfg_error_o=1 after the address-3 read.

Source files
------------

// File: rtl/ic_pkg.sv
// Shared constants and state encodings for the interrupt-controller host master.
// Line count, priority width and register map are fixed here for every block that imports them.
package ic_pkg;

  localparam int NUM_INTR = 16;
  localparam int PRIO_W   = 4;
  localparam int IDX_W    = $clog2(NUM_INTR);

  // Priority registers occupy consecutive addresses starting at this base
  localparam logic [7:0] PRIO_BASE = 8'h00;

  typedef enum logic [7:0] {
    S_IDLE       = 8'b0000_0001,
    S_CFG_ACCESS = 8'b0000_0010,
    S_RD_ACCESS  = 8'b0000_0100,
    S_CFG_GAP    = 8'b0000_1000,
    S_WAIT_INTR  = 8'b0001_0000,
    S_SERVICE    = 8'b0010_0000,
    S_ACK        = 8'b0100_0000,
    S_DRAIN      = 8'b1000_0000
  } state_t;

  function automatic logic [NUM_INTR-1:0] line_onehot(input logic [IDX_W-1:0] id);
    return NUM_INTR'(1) << id;
  endfunction

endpackage

// File: rtl/ic_host_timer.sv
// Loadable down-counter with a zero flag; stops at zero until reloaded.
// The host master shares one instance between access timeouts and the service delay.
module ic_host_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ic_host_master.sv
// Host-side initiator: programs one priority register per interrupt line, then services interrupts.
// Define IC_HOST_READBACK_EN to follow every successful write with a verifying read of the same register.
module ic_host_master
  import ic_pkg::*;
#(
  parameter int SERVICE_CYCLES = 3,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                       pclk_i,
  input  logic                       prst_i,
  input  logic                       start_i,
  input  logic [NUM_INTR*PRIO_W-1:0] prio_cfg_i,
  output logic [7:0]                 paddr_o,
  output logic [7:0]                 pwdata_o,
  output logic                       pwrite_o,
  output logic                       penable_o,
  input  logic [7:0]                 prdata_i,
  input  logic                       pready_i,
  input  logic                       perror_i,
  input  logic                       intr_valid_i,
  input  logic [PRIO_W-1:0]          intr_to_service_i,
  output logic                       intr_serviced_o,
  output logic [NUM_INTR-1:0]        intr_clear_o,
  output logic                       cfg_done_o,
  output logic                       cfg_error_o,
  output logic [15:0]                service_count_o
);

  localparam int TMR_MAX = (SERVICE_CYCLES > TIMEOUT_CYCLES) ? SERVICE_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  // Loads are one less than the cycle count because the zero cycle itself is counted
  localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] SVC_LOAD = TMR_W'(SERVICE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INTR - 1);

  state_t                     state;
  state_t                     state_next;
  logic [NUM_INTR*PRIO_W-1:0] prio_q;
  logic [IDX_W-1:0]           idx;
  logic [PRIO_W-1:0]          svc_id;
  logic [PRIO_W-1:0]          cur_prio;
  logic                       rd_next;
  logic                       rd_mismatch;
  logic                       in_access;
  logic                       access_fail;
  logic                       tmr_load;
  logic [TMR_W-1:0]           tmr_value;
  logic                       tmr_zero;

  ic_host_timer #(.WIDTH(TMR_W)) u_timer (
    .clk        (pclk_i),
    .rst_n      (prst_i),
    .load       (tmr_load),
    .load_value (tmr_value),
    .zero       (tmr_zero)
  );

  assign cur_prio    = prio_q[idx*PRIO_W +: PRIO_W];
  assign in_access   = (state == S_CFG_ACCESS) || (state == S_RD_ACCESS);
  assign access_fail = in_access && ((pready_i && perror_i) || (!pready_i && tmr_zero));

`ifdef IC_HOST_READBACK_EN
  logic unused_prdata_hi;
  assign unused_prdata_hi = ^prdata_i[7:PRIO_W];

  // Remembers that the write just finished cleanly, so the gap leads into a read of the same address
  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      rd_next <= 1'b0;
    end else if (state == S_CFG_ACCESS) begin
      rd_next <= pready_i && !perror_i;
    end else if (state == S_CFG_GAP) begin
      rd_next <= 1'b0;
    end
  end

  assign rd_mismatch = (state == S_RD_ACCESS) && pready_i && !perror_i &&
                       (prdata_i[PRIO_W-1:0] != cur_prio);
`else
  logic unused_prdata;
  assign unused_prdata = ^prdata_i;
  assign rd_next       = 1'b0;
  assign rd_mismatch   = 1'b0;
`endif

  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      state           <= S_IDLE;
      prio_q          <= '0;
      idx             <= '0;
      svc_id          <= '0;
      cfg_done_o      <= 1'b0;
      cfg_error_o     <= 1'b0;
      service_count_o <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && start_i) begin
        prio_q <= prio_cfg_i;
      end
      if (state == S_CFG_GAP && !rd_next) begin
        idx <= idx + 1'b1;
        if (idx == LAST_IDX) begin
          cfg_done_o <= 1'b1;
        end
      end
      if (access_fail || rd_mismatch) begin
        cfg_error_o <= 1'b1;
      end
      if (state == S_WAIT_INTR && intr_valid_i) begin
        svc_id <= intr_to_service_i;
      end
      if (state == S_ACK) begin
        service_count_o <= service_count_o + 16'd1;
      end
    end
  end

  always_comb begin
    state_next      = state;
    tmr_load        = 1'b0;
    tmr_value       = '0;
    paddr_o         = '0;
    pwdata_o        = '0;
    pwrite_o        = 1'b0;
    penable_o       = 1'b0;
    intr_serviced_o = 1'b0;
    intr_clear_o    = '0;
    unique case (state)
      S_IDLE: begin
        if (start_i) begin
          state_next = S_CFG_ACCESS;
          tmr_load   = 1'b1;
          tmr_value  = TMO_LOAD;
        end
      end
      S_CFG_ACCESS: begin
        paddr_o   = PRIO_BASE + 8'(idx);
        pwdata_o  = 8'(cur_prio);
        pwrite_o  = 1'b1;
        penable_o = 1'b1;
        if (pready_i || tmr_zero) begin
          state_next = S_CFG_GAP;
        end
      end
      S_RD_ACCESS: begin
        paddr_o   = PRIO_BASE + 8'(idx);
        penable_o = 1'b1;
        if (pready_i || tmr_zero) begin
          state_next = S_CFG_GAP;
        end
      end
      S_CFG_GAP: begin
        if (rd_next) begin
          state_next = S_RD_ACCESS;
          tmr_load   = 1'b1;
          tmr_value  = TMO_LOAD;
        end else if (idx == LAST_IDX) begin
          state_next = S_WAIT_INTR;
        end else begin
          state_next = S_CFG_ACCESS;
          tmr_load   = 1'b1;
          tmr_value  = TMO_LOAD;
        end
      end
      S_WAIT_INTR: begin
        if (intr_valid_i) begin
          state_next = S_SERVICE;
          tmr_load   = 1'b1;
          tmr_value  = SVC_LOAD;
        end
      end
      S_SERVICE: begin
        if (tmr_zero) begin
          state_next = S_ACK;
        end
      end
      S_ACK: begin
        intr_serviced_o = 1'b1;
        intr_clear_o    = line_onehot(svc_id);
        state_next      = S_DRAIN;
      end
      S_DRAIN: begin
        // A valid still held from the serviced interrupt must drop before the next one is taken
        if (!intr_valid_i) begin
          state_next = S_WAIT_INTR;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ic_host_master.sv
// Self-checking bench for ic_host_master: scoreboarded APB transfers and interrupt services.
// Honors IC_HOST_READBACK_EN when the design is built with it.
module tb_ic_host_master;
  import ic_pkg::*;

  localparam int SERVICE_CYCLES = 3;
  localparam int TIMEOUT_CYCLES = 15;
  localparam int RESP_DELAY     = 2;

  logic                       pclk_i;
  logic                       prst_i;
  logic                       start_i;
  logic [NUM_INTR*PRIO_W-1:0] prio_cfg_i;
  logic [7:0]                 paddr_o;
  logic [7:0]                 pwdata_o;
  logic                       pwrite_o;
  logic                       penable_o;
  logic [7:0]                 prdata_i;
  logic                       pready_i;
  logic                       perror_i;
  logic                       intr_valid_i;
  logic [PRIO_W-1:0]          intr_to_service_i;
  logic                       intr_serviced_o;
  logic [NUM_INTR-1:0]        intr_clear_o;
  logic                       cfg_done_o;
  logic                       cfg_error_o;
  logic [15:0]                service_count_o;

  int check_count = 0;
  int error_count = 0;

  logic [16:0] xfer_q[$];
  logic [15:0] svc_q[$];
  logic [7:0]  regs[256];
  int          hang_addr = -1;
  bit          corrupt   = 1'b0;
  int          acc_len   = 0;
  bit          cur_hang  = 1'b0;

  ic_host_master #(
    .SERVICE_CYCLES (SERVICE_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .pclk_i            (pclk_i),
    .prst_i            (prst_i),
    .start_i           (start_i),
    .prio_cfg_i        (prio_cfg_i),
    .paddr_o           (paddr_o),
    .pwdata_o          (pwdata_o),
    .pwrite_o          (pwrite_o),
    .penable_o         (penable_o),
    .prdata_i          (prdata_i),
    .pready_i          (pready_i),
    .perror_i          (perror_i),
    .intr_valid_i      (intr_valid_i),
    .intr_to_service_i (intr_to_service_i),
    .intr_serviced_o   (intr_serviced_o),
    .intr_clear_o      (intr_clear_o),
    .cfg_done_o        (cfg_done_o),
    .cfg_error_o       (cfg_error_o),
    .service_count_o   (service_count_o)
  );

  initial pclk_i = 1'b0;
  always #5 pclk_i = ~pclk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Responder: checks each new access against the scoreboard and answers after RESP_DELAY cycles
  always @(negedge pclk_i) begin
    if (penable_o) begin
      if (acc_len == 0) begin
        checkOutput("xfer_pending", xfer_q.size() != 0, 1);
        if (xfer_q.size() != 0) begin
          checkOutput("xfer", {pwrite_o, paddr_o, pwdata_o}, xfer_q.pop_front());
        end
        cur_hang = pwrite_o && (int'(paddr_o) == hang_addr);
      end
      acc_len++;
      if (!cur_hang && acc_len == RESP_DELAY) begin
        pready_i = 1'b1;
        prdata_i = regs[paddr_o] ^ ((corrupt && paddr_o == 8'd3) ? 8'h01 : 8'h00);
        if (pwrite_o) regs[paddr_o] = pwdata_o;
      end else begin
        pready_i = 1'b0;
      end
    end else begin
      if (acc_len != 0) begin
        checkOutput("access_len", acc_len, cur_hang ? TIMEOUT_CYCLES : RESP_DELAY);
      end
      acc_len  = 0;
      pready_i = 1'b0;
    end
  end

  // Service monitor: every pulse must match a queued request and clear exactly that line
  always @(negedge pclk_i) begin
    if (intr_serviced_o) begin
      checkOutput("svc_expected", svc_q.size() != 0, 1);
      if (svc_q.size() != 0) begin
        checkOutput("intr_clear", intr_clear_o, svc_q.pop_front());
      end
    end
  end

  task automatic checkResetState(input string pfx);
    checkOutput({pfx, "_paddr"}, paddr_o, 0);
    checkOutput({pfx, "_pwdata"}, pwdata_o, 0);
    checkOutput({pfx, "_pwrite"}, pwrite_o, 0);
    checkOutput({pfx, "_penable"}, penable_o, 0);
    checkOutput({pfx, "_serviced"}, intr_serviced_o, 0);
    checkOutput({pfx, "_clear"}, intr_clear_o, 0);
    checkOutput({pfx, "_cfg_done"}, cfg_done_o, 0);
    checkOutput({pfx, "_cfg_error"}, cfg_error_o, 0);
    checkOutput({pfx, "_count"}, service_count_o, 0);
  endtask

  // Loads priorities (identity or reversed), queues the expected transfers and pulses start
  task automatic applyStimulus(input bit reversed);
    logic [PRIO_W-1:0] p;
    for (int k = 0; k < NUM_INTR; k++) begin
      p = reversed ? PRIO_W'(NUM_INTR - 1 - k) : PRIO_W'(k);
      prio_cfg_i[k*PRIO_W +: PRIO_W] = p;
      xfer_q.push_back({1'b1, 8'(k), 8'(p)});
`ifdef IC_HOST_READBACK_EN
      if (k != hang_addr) xfer_q.push_back({1'b0, 8'(k), 8'h00});
`endif
    end
    @(posedge pclk_i); #1;
    start_i = 1'b1;
    @(posedge pclk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic waitCfgDone(input int budget);
    int n = 0;
    while (!cfg_done_o && n < budget) begin
      @(posedge pclk_i); #1;
      n++;
    end
    checkOutput("cfg_done", cfg_done_o, 1);
    checkOutput("xfer_left", xfer_q.size(), 0);
    checkOutput("idle_bus", penable_o, 0);
  endtask

  task automatic serviceIntr(input logic [PRIO_W-1:0] id, input int exp_count, input int hold);
    int lat;
    @(posedge pclk_i); #1;
    intr_valid_i      = 1'b1;
    intr_to_service_i = id;
    svc_q.push_back(16'(1) << id);
    for (lat = 1; lat <= 20; lat++) begin
      @(posedge pclk_i); #1;
      if (lat == 1) intr_to_service_i = id ^ 4'hF;
      if (intr_serviced_o) break;
    end
    checkOutput("svc_latency", lat, SERVICE_CYCLES + 1);
    repeat (hold) begin
      @(posedge pclk_i); #1;
      checkOutput("count_hold", service_count_o, exp_count);
    end
    intr_valid_i = 1'b0;
  endtask

  initial begin
    prst_i = 1'b1; start_i = 1'b0; prio_cfg_i = '0; prdata_i = '0;
    pready_i = 1'b0; perror_i = 1'b0; intr_valid_i = 1'b0; intr_to_service_i = '0;
    for (int i = 0; i < 256; i++) regs[i] = 8'h00;
    #2 prst_i = 1'b0;
    repeat (3) @(posedge pclk_i);
    #1 checkResetState("reset");
    @(negedge pclk_i) prst_i = 1'b1;

    // Identity priorities; an interrupt raised during configuration must be ignored
    $display("[TB] configuration with priorities 0..15");
    intr_valid_i = 1'b1; intr_to_service_i = 4'd2;
    applyStimulus(1'b0);
    repeat (20) @(posedge pclk_i);
    #1 intr_valid_i = 1'b0;
    waitCfgDone(300);
    checkOutput("cfg_error_clean", cfg_error_o, 0);

    $display("[TB] interrupt servicing");
    serviceIntr(4'd9, 1, 3);
    checkOutput("count_after_drop", service_count_o, 1);
    serviceIntr(4'd4, 2, 1);

    // Start outside idle must not restart configuration
    @(posedge pclk_i); #1 start_i = 1'b1;
    @(posedge pclk_i); #1 start_i = 1'b0;
    repeat (3) begin
      @(posedge pclk_i); #1;
      checkOutput("start_ignored", penable_o, 0);
    end

    $display("[TB] reset during service");
    @(posedge pclk_i); #1 intr_valid_i = 1'b1; intr_to_service_i = 4'd7;
    @(posedge pclk_i); #2 prst_i = 1'b0;
    #1 checkResetState("async_reset");
    intr_valid_i = 1'b0;
    @(negedge pclk_i) prst_i = 1'b1;
    repeat (5) @(posedge pclk_i);
    #1 checkOutput("no_auto_start", penable_o, 0);
    checkOutput("no_auto_done", cfg_done_o, 0);

    $display("[TB] configuration with address 5 unanswered");
    hang_addr = 5;
    applyStimulus(1'b1);
    waitCfgDone(400);
    checkOutput("cfg_error_timeout", cfg_error_o, 1);
    hang_addr = -1;

`ifdef IC_HOST_READBACK_EN
    $display("[TB] readback with corrupted address 3");
    @(negedge pclk_i) prst_i = 1'b0;
    @(negedge pclk_i) prst_i = 1'b1;
    corrupt = 1'b1;
    applyStimulus(1'b0);
    waitCfgDone(500);
    checkOutput("cfg_error_readback", cfg_error_o, 1);
    corrupt = 1'b0;
`endif

    repeat (3) @(posedge pclk_i);
    checkOutput("svc_left", svc_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
